seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader.sv | 101 ++++++++++
 tb/tb_seven_segment_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: debounces a 7-segment display and presents each newly settled digit as a BCD word.
// Define SEVEN_SEGMENT_READER_SYNC_EN to pass A..G through a two-flop synchronizer first.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic Ready,
  output logic W,
  output logic X,
  output logic Y,
  output logic Z,
  output logic Valid,
  output logic Err,
  output logic Overrun
);
  logic [6:0] seg, s, prev_q, l_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] word_q, word_d, dec;
  logic valid_q, valid_d, err_q, err_d, ovr_q, ovr_d, same, stable, accept;
  assign seg = {A, B, C, D, E, F, G};
`ifdef SEVEN_SEGMENT_READER_SYNC_EN
  logic [6:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= seg;
      sync2_q <= sync1_q;
    end
  end
  assign s = sync2_q;
`else
  assign s = seg;
`endif
  // 4'hf doubles as the illegal-pattern marker; no legal digit decodes to it
  always_comb begin
    dec = 4'hf;
    case (s)
      7'b1111110: dec = 4'd0;
      7'b0110000: dec = 4'd1;
      7'b1101101: dec = 4'd2;
      7'b1111001: dec = 4'd3;
      7'b0110011: dec = 4'd4;
      7'b1011011: dec = 4'd5;
      7'b1011111: dec = 4'd6;
      7'b1110000: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1111011: dec = 4'd9;
      default:    dec = 4'hf;
    endcase
  end
  assign same   = s == prev_q;
  assign cnt_d  = same ? cnt_q + {7'd0, cnt_q != 8'hff} : 8'd0;
  // run length of identical samples is cnt_q+2 when the current sample matches the previous one
  assign stable = same ? ({2'b0, cnt_q} + 10'd2 >= 10'(STABLE_CYCLES)) : (STABLE_CYCLES == 1);
  assign accept = stable && s != l_q;
  always_comb begin
    word_d  = word_q;
    err_d   = err_q;
    valid_d = valid_q && !Ready;
    ovr_d   = ovr_q;
    if (accept && s != 7'd0) begin
      word_d  = dec;
      err_d   = dec == 4'hf;
      valid_d = 1'b1;
      ovr_d   = ovr_q | (valid_q & ~Ready);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= s;
      cnt_q   <= cnt_d;
      l_q     <= accept ? s : l_q;
      word_q  <= word_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign {W, X, Y, Z} = word_q;
  assign Valid        = valid_q;
  assign Err          = err_q;
  assign Overrun      = ovr_q;
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_seven_segment_reader;
  localparam int N = 4;
`ifdef SEVEN_SEGMENT_READER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 0, reset = 1, Ready = 0;
  logic A = 0, B = 0, C = 0, D = 0, E = 0, F = 0, G = 0;
  logic W, X, Y, Z, Valid, Err, Overrun;
  int total = 0, bad = 0;
  logic [6:0] segs [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic [6:0] dly[$], shist[$], m_l;
  logic [3:0] m_word;
  logic m_err, m_valid, m_ovr, prev_v;
  int edge_n, first_v, rises;

  always #5 clk = ~clk;

  seven_segment_reader #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .Ready(Ready), .W(W), .X(X), .Y(Y), .Z(Z), .Valid(Valid), .Err(Err), .Overrun(Overrun)
  );

  task automatic step(input logic [6:0] pat, input logic rdy, input logic rst);
    logic [6:0] s;
    logic st, acc;
    {A, B, C, D, E, F, G} = pat;
    Ready = rdy;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      dly.delete();
      for (int i = 0; i < LAT; i++) dly.push_back(7'd0);
      shist.delete();
      m_l = 0; m_word = 0; m_err = 0; m_valid = 0; m_ovr = 0;
      edge_n = 0; first_v = -1; rises = 0;
    end else begin
      dly.push_back(pat);
      s = dly.pop_front();
      shist.push_back(s);
      if (shist.size() > N) void'(shist.pop_front());
      st = shist.size() == N;
      foreach (shist[i]) if (shist[i] != s) st = 0;
      acc = st && s != m_l && s != 7'd0;
      if (st) m_l = s;
      if (acc) begin
        m_ovr = m_ovr | (m_valid & ~rdy);
        m_valid = 1;
        m_word = 4'hf;
        m_err = 1;
        for (int i = 0; i < 10; i++) if (segs[i] == s) begin m_word = 4'(i); m_err = 0; end
      end else if (rdy) m_valid = 0;
      edge_n++;
    end
    #1;
    if (!rst && Valid && !prev_v) begin
      rises++;
      if (first_v < 0) first_v = edge_n;
    end
    prev_v = Valid;
  endtask

  task automatic hold(input logic [6:0] pat, input logic rdy, input int n);
    repeat (n) step(pat, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(7'd0, 1'b0, 1'b1);
    step(7'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    hold(7'b1101101, 1'b0, 8);
    repeat (6) step(7'b0110000, 1'b1, 1'b1);
    total++;
    if ({W, X, Y, Z, Valid, Err, Overrun} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000", {W, X, Y, Z, Valid, Err, Overrun});
    end
  endtask

  task automatic test_single();
    do_reset();
    hold(7'b0110000, 1'b1, 10);
    total++;
    if (first_v != N + LAT) begin
      bad++;
      $display("FAIL single_latency: got edge %0d want %0d", first_v, N + LAT);
    end
    total++;
    if (rises != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", rises); end
    total++;
    if ({W, X, Y, Z, Err, Valid} !== 6'b000100) begin
      bad++;
      $display("FAIL single_word: got %b want 000100", {W, X, Y, Z, Err, Valid});
    end
  endtask

  task automatic test_no_intermediate();
    do_reset();
    hold(7'b1111111, 1'b1, 3);
    hold(7'b1111011, 1'b1, 10);
    total++;
    if (rises != 1) begin bad++; $display("FAIL settle_pulses: got %0d want 1", rises); end
    total++;
    if ({W, X, Y, Z, Err} !== 5'b10010) begin
      bad++;
      $display("FAIL settle_word: got %b want 10010", {W, X, Y, Z, Err});
    end
  endtask

  task automatic test_illegal();
    do_reset();
    hold(7'b1000001, 1'b0, 10);
    total++;
    if ({W, X, Y, Z, Err, Valid} !== 6'b111111) begin
      bad++;
      $display("FAIL illegal_word: got %b want 111111", {W, X, Y, Z, Err, Valid});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    hold(7'b0110000, 1'b0, 8);
    hold(7'b0000000, 1'b0, 8);
    hold(7'b1101101, 1'b0, 8);
    total++;
    if ({W, X, Y, Z, Err, Valid, Overrun} !== 7'b0010011) begin
      bad++;
      $display("FAIL overrun_word: got %b want 0010011", {W, X, Y, Z, Err, Valid, Overrun});
    end
    step(7'b1101101, 1'b1, 1'b0);
    total++;
    if ({W, X, Y, Z, Err, Valid, Overrun} !== 7'b0010001) begin
      bad++;
      $display("FAIL overrun_consume: got %b want 0010001", {W, X, Y, Z, Err, Valid, Overrun});
    end
  endtask

  task automatic test_blank_repeat();
    do_reset();
    hold(7'b1011011, 1'b1, 8);
    hold(7'b0000000, 1'b1, 8);
    hold(7'b1011011, 1'b1, 8);
    total++;
    if (rises != 2) begin bad++; $display("FAIL blank_pulses: got %0d want 2", rises); end
    total++;
    if ({W, X, Y, Z, Err, Overrun} !== 6'b010100) begin
      bad++;
      $display("FAIL blank_word: got %b want 010100", {W, X, Y, Z, Err, Overrun});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(7'b1111001, 1'b1, 2);
    step(7'b1111001, 1'b1, 1'b1);
    step(7'b1111001, 1'b1, 1'b1);
    total++;
    if (Valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", Valid); end
    hold(7'b1111001, 1'b1, 10);
    total++;
    if (first_v != N + LAT) begin
      bad++;
      $display("FAIL midreset_latency: got edge %0d want %0d", first_v, N + LAT);
    end
    total++;
    if ({W, X, Y, Z, Err, rises == 1} !== 6'b001101) begin
      bad++;
      $display("FAIL midreset_word: got %b%b pulses %0d want 00110 pulses 1", {W, X, Y, Z}, Err, rises);
    end
  endtask

  task automatic test_random();
    logic [6:0] pat;
    int n;
    logic rst;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      n = $urandom_range(8);
      pat = n < 1 ? 7'd0 : (n < 2 ? 7'($urandom) : segs[$urandom_range(9)]);
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        rst = $urandom_range(99) == 0;
        step(pat, 1'($urandom_range(1)), rst);
        total++;
        if ({W, X, Y, Z, Valid, Err, Overrun} !== {m_word, m_valid, m_err, m_ovr}) begin
          bad++;
          $display("FAIL random_cycle: got %b want %b", {W, X, Y, Z, Valid, Err, Overrun},
                   {m_word, m_valid, m_err, m_ovr});
        end
      end
    end
  endtask

  initial begin
    prev_v = 0;
    do_reset();
    test_reset();
    test_single();
    test_no_intermediate();
    test_illegal();
    test_overrun();
    test_blank_repeat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
